// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word reads to instruction memory,
// buffers returned words in a small queue and hands them to decode over valid/ready.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [15:0] fetch_cnt
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic {ST_RUN, ST_DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   fetch_cnt_q, fetch_cnt_d;
   logic [31:0]   inst_q [QDEPTH];
   logic [31:0]   tag_q  [QDEPTH];

   logic          transfer;
   logic          push;
   logic [CW:0]   occ;

   assign if_valid  = (count_q != '0);
   assign if_inst   = if_valid ? inst_q[head_q] : 32'h0;
   assign if_pc     = if_valid ? tag_q[head_q]  : 32'h0;
   assign fetch_cnt = fetch_cnt_q;
   assign mem_addr  = pc_q;

   assign transfer = if_valid & if_ready & ~redirect;
   assign push     = inflight_q & (state_q == ST_RUN) & ~redirect;

   // A slot freed by this cycle's transfer counts as free, which is what lets the
   // two-entry queue sustain one instruction per cycle.
   assign occ     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, transfer};
   assign mem_req = rst & fetch_en & ~redirect & (occ < (CW+1)'(QDEPTH));

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      inflight_d  = inflight_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      fetch_cnt_d = fetch_cnt_q;
      if (redirect) begin
         // A response due this cycle belongs to the old stream and is never queued.
         state_d    = inflight_q ? ST_DROP : ST_RUN;
         pc_d       = {redirect_pc[31:2], 2'b00};
         inflight_d = 1'b0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         state_d    = ST_RUN;
         inflight_d = mem_req;
         if (mem_req) begin
            pc_d     = pc_q + 32'(PC_STEP);
            req_pc_d = pc_q;
         end
         if (push) begin
            tail_d = tail_q + 1'b1;
         end
         if (transfer) begin
            head_d      = head_q + 1'b1;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
         end
         count_d = count_q + CW'(push) - CW'(transfer);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         inflight_q  <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         fetch_cnt_q <= 16'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         inflight_q  <= inflight_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            inst_q[i] <= 32'h0;
            tag_q[i]  <= 32'h0;
         end
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (tail_q == PW'(i))) begin
               inst_q[i] <= mem_rdata;
               tag_q[i]  <= req_pc_q;
            end
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !transfer && (count_q == CW'(QDEPTH))));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: cycle table for timing plus a request-ordered scoreboard
// that predicts every delivered {pc, instruction} pair.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_en = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [15:0] fetch_cnt;

   always #5 clk = ~clk;

   inst_fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(4), .QDEPTH(2)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
      .fetch_cnt(fetch_cnt)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_4020;
         32'h4:   return 32'h8D09_0004;
         32'h8:   return 32'h8D0A_0008;
         default: return 32'hC000_0000 ^ a;
      endcase
   endfunction

   // Instruction memory: data for a request appears exactly one cycle later.
   always @(posedge clk) mem_rdata <= mem_req ? mem_fn(mem_addr) : 32'hDEAD_BEEF;

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sbq[$];
   exp_t        sb_e;
   logic [31:0] exp_pc = 32'h0;
   logic [15:0] exp_cnt = 16'h0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_inst, prev_pc;

   // Scoreboard: push on request issue, clear on redirect, pop and compare on transfer.
   always @(negedge clk) begin
      if (rst) begin
         chk("sb_fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
         if (prev_hold) begin
            chk("hold_inst", if_inst, prev_inst);
            chk("hold_pc", if_pc, prev_pc);
         end
         if (mem_req) begin
            chk("sb_mem_addr", mem_addr, exp_pc);
            sbq.push_back('{exp_pc, mem_fn(exp_pc)});
            exp_pc = exp_pc + 32'd4;
         end
         prev_hold = if_valid && !if_ready && !redirect;
         prev_inst = if_inst;
         prev_pc   = if_pc;
         if (redirect) begin
            sbq.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
         end else if (if_valid && if_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow actual=transfer pc=%h required=no_transfer", if_pc);
            end else begin
               sb_e = sbq.pop_front();
               chk("sb_if_pc", if_pc, sb_e.pc);
               chk("sb_if_inst", if_inst, sb_e.inst);
               $display("xfer pc=%h inst=%h cnt=%0d", if_pc, if_inst, fetch_cnt);
            end
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   task automatic reset_checks(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
      chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
      chk({tag, "_if_inst"}, if_inst, 32'h0);
      chk({tag, "_if_pc"}, if_pc, 32'h0);
      chk({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'h0);
   endtask

   task automatic sb_clear();
      sbq.delete();
      exp_pc    = 32'h0;
      exp_cnt   = 16'h0;
      prev_hold = 1'b0;
   endtask

   // Leaves the bench at posedge+1 of cycle 0 after reset release.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      #1;
      reset_checks("rst");
      sb_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // ctl = {reset_before, fetch_en, if_ready, redirect}; ev = {mem_req, if_valid}
   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] rpc;
      logic [1:0]  ev;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rpc, input logic [1:0] ev,
                               input logic [31:0] ea, input logic [31:0] ep, input logic [15:0] ec);
      vec_t v;
      v.ctl = ctl; v.rpc = rpc; v.ev = ev; v.e_addr = ea; v.e_pc = ep; v.e_cnt = ec;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Streaming from reset: first if_valid at cycle 2, then one per cycle.
      vq.push_back(mk(4'b1110, 32'h0,  2'b10, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h4,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h8,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'hC,  32'h4,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h10, 32'h8,  16'd2));
      vq.push_back(mk(4'b0000, 32'h0,  2'b01, 32'h0,  32'hC,  16'd3));
      // Decode stalled five cycles: queue fills, requests stop, head holds 0x0.
      vq.push_back(mk(4'b1100, 32'h0,  2'b10, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0100, 32'h0,  2'b10, 32'h4,  32'h0,  16'd0));
      vq.push_back(mk(4'b0100, 32'h0,  2'b01, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0100, 32'h0,  2'b01, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0100, 32'h0,  2'b01, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h8,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'hC,  32'h4,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h10, 32'h8,  16'd2));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h14, 32'hC,  16'd3));
      // Redirect with one queued and one in flight; handshake in that cycle discarded.
      vq.push_back(mk(4'b1100, 32'h0,  2'b10, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0100, 32'h0,  2'b10, 32'h4,  32'h0,  16'd0));
      vq.push_back(mk(4'b0111, 32'h14, 2'b01, 32'h0,  32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h14, 32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h18, 32'h0,  16'd0));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h1C, 32'h14, 16'd0));
      // Unaligned target 0x1B is fetched as 0x18.
      vq.push_back(mk(4'b0111, 32'h1B, 2'b01, 32'h0,  32'h18, 16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h18, 32'h0,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h1C, 32'h0,  16'd1));
      // Back-to-back redirects: only the 0x40 stream survives.
      vq.push_back(mk(4'b0111, 32'h20, 2'b01, 32'h0,  32'h18, 16'd1));
      vq.push_back(mk(4'b0111, 32'h40, 2'b00, 32'h0,  32'h0,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h40, 32'h0,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b10, 32'h44, 32'h0,  16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h48, 32'h40, 16'd1));
      vq.push_back(mk(4'b0110, 32'h0,  2'b11, 32'h4C, 32'h44, 16'd2));

      foreach (vq[i]) begin
         if (vq[i].ctl[3]) begin
            do_reset();
         end else begin
            @(posedge clk);
            #1;
         end
         fetch_en    = vq[i].ctl[2];
         if_ready    = vq[i].ctl[1];
         redirect    = vq[i].ctl[0];
         redirect_pc = vq[i].rpc;
         @(negedge clk);
         chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vq[i].ev[1]));
         if (vq[i].ev[1]) chk($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].e_addr);
         chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vq[i].ev[0]));
         if (vq[i].ev[0]) chk($sformatf("v%0d_if_pc", i), if_pc, vq[i].e_pc);
         chk($sformatf("v%0d_fetch_cnt", i), 32'(fetch_cnt), 32'(vq[i].e_cnt));
      end

      // Asynchronous reset in the middle of a stream.
      do_reset();
      if_ready = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      chk("pre_rst_cnt", 32'(fetch_cnt), 32'd4);
      rst = 1'b0;
      #1;
      reset_checks("mid_rst");
      sb_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; if_ready = 1'b0; fetch_en = 1'b1; redirect = 1'b0;
      @(negedge clk);
      chk("restart_mem_req", 32'(mem_req), 32'h1);
      chk("restart_mem_addr", mem_addr, 32'h0);

      // Counter wrap: preload 16'hFFFF, then one transfer.
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #2;
      force dut.fetch_cnt_q = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      #1;
      release dut.fetch_cnt_q;
      @(posedge clk);
      #1;
      if_ready = 1'b1;
      @(negedge clk);
      chk("wrap_if_valid", 32'(if_valid), 32'h1);
      chk("wrap_if_pc", if_pc, 32'h0);
      @(posedge clk);
      #1;
      if_ready = 1'b0;
      @(negedge clk);
      chk("cnt_wrap", 32'(fetch_cnt), 32'h0);
      chk("wrap_next_head", if_pc, 32'h4);
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
